// File: rtl/mem_pkg.sv
// Memory-op encodings and response tags shared by the arbiter, LSU and memory model.
package mem_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned STREAK_W = 4;

  localparam logic [OP_W-1:0] MEM_DISABLE   = 2'b00;
  localparam logic [OP_W-1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [OP_W-1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [OP_W-1:0] MEM_WRITE     = 2'b11;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } respTag_t;

  function automatic logic isReadOp(input logic [OP_W-1:0] op);
    return (op == MEM_READ_SEXT) || (op == MEM_READ_ZEXT);
  endfunction

endpackage

// File: rtl/arb_priority_streak.sv
// D-priority grant select with a bounded D streak so a waiting fetch is never starved.
module arb_priority_streak
  import mem_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                iValid,
  input  logic                dValid,
  input  logic                memReady,
  input  logic [STREAK_W-1:0] streak,
  output logic                iSel,
  output logic                dSel,
  output logic [STREAK_W-1:0] streakNext
);

  logic atLimit;

  assign atLimit = (streak >= STREAK_W'(MAX_D_STREAK));

  always_comb begin
    iSel       = 1'b0;
    dSel       = 1'b0;
    streakNext = streak;

    if (memReady) begin
      if (dValid && !(iValid && atLimit)) begin
        dSel = 1'b1;
      end else if (iValid) begin
        iSel = 1'b1;
      end
    end

    // A stalled cycle with I still waiting keeps the streak as-is.
    if (!iValid || iSel) begin
      streakNext = '0;
    end else if (dSel && !atLimit) begin
      streakNext = streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one single-port memory and
// steers the 1-cycle read response back to the requester that issued it.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              iReq,
  input  logic [WORD_W-1:0] iAddr,
  input  logic              iFlush,
  output logic              iGnt,
  output logic              iRvalid,
  output logic [WORD_W-1:0] iRdata,
  output logic [WORD_W-1:0] iRaddr,

  input  logic              dReq,
  input  logic [OP_W-1:0]   dOp,
  input  logic [WORD_W-1:0] dAddr,
  input  logic [WORD_W-1:0] dWdata,
  output logic              dGnt,
  output logic              dRvalid,
  output logic [WORD_W-1:0] dRdata,

  output logic [OP_W-1:0]   mOp,
  output logic [WORD_W-1:0] mAddr,
  output logic [WORD_W-1:0] mWdata,
  input  logic [WORD_W-1:0] mRdata,
  input  logic              mNotReady
);

  logic                iValid;
  logic                dValid;
  logic                iSel;
  logic                dSel;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streakNext;
  respTag_t            tag;
  respTag_t            tagNext;

  // Gating with reset_n keeps every memory-side output quiet while in reset.
  assign iValid = reset_n & iReq & ~iFlush;
  assign dValid = reset_n & dReq & (dOp != MEM_DISABLE);

  arb_priority_streak #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) uPrio (
    .iValid    (iValid),
    .dValid    (dValid),
    .memReady  (~mNotReady),
    .streak    (streak),
    .iSel      (iSel),
    .dSel      (dSel),
    .streakNext(streakNext)
  );

  always_comb begin
    iGnt    = iSel;
    dGnt    = dSel;
    mOp     = MEM_DISABLE;
    mAddr   = '0;
    mWdata  = '0;
    tagNext = TAG_NONE;
    if (iSel) begin
      mOp     = MEM_READ_ZEXT;
      mAddr   = iAddr;
      tagNext = TAG_I;
    end else if (dSel) begin
      mOp    = dOp;
      mAddr  = dAddr;
      mWdata = dWdata;
      if (isReadOp(dOp)) begin
        tagNext = TAG_D;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag    <= TAG_NONE;
      streak <= '0;
      iRaddr <= '0;
    end else begin
      tag    <= tagNext;
      streak <= streakNext;
      if (iSel) begin
        iRaddr <= iAddr;
      end
    end
  end

  // A redirect in the response cycle kills the stale instruction.
  always_comb begin
    iRvalid = (tag == TAG_I) && !iFlush;
    dRvalid = (tag == TAG_D);
    iRdata  = iRvalid ? mRdata : '0;
    dRdata  = dRvalid ? mRdata : '0;
  end

endmodule
